// File: rtl/sevenseg_mux_display.sv
// Time-multiplexed seven-segment driver: shadow-latched digits, programmable scan
// rate, hex/decimal glyphs, per-digit dp/blank, leading-zero suppression, polarity.
module sevenseg_mux_display #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int HEX_MODE       = 1,
  parameter int LZ_SUPPRESS    = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   data_sh_q, data_sh_d;
  logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
  logic [DIGITS-1:0]     blank_sh_q, blank_sh_d;
  logic                  tick_q, tick_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     sel_q, sel_d;

  logic                  wrap;
  logic                  lead;
  logic [DIGITS-1:0]     supp;
  logic [3:0]            nib;
  logic                  dark;
  logic                  pt;
  logic [DIGITS-1:0]     sel_raw;
  logic [6:0]            seg_raw;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1110011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    if (HEX_MODE == 0 && n > 4'd9) g = 7'b0000000;
    return g;
  endfunction

  // Scan timing and shadow capture.
  always_comb begin
    wrap       = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d      = wrap ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    if (wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    tick_d     = wrap;
    data_sh_d  = load ? data  : data_sh_q;
    dp_sh_d    = load ? dp_in : dp_sh_q;
    blank_sh_d = load ? blank : blank_sh_q;
  end

  // A digit stays suppressed only while every nibble from the top down to it is
  // zero and no dp has been requested at or above it.
  always_comb begin
    lead = (LZ_SUPPRESS != 0);
    supp = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (dp_sh_q[k] || (data_sh_q[4*k +: 4] != 4'h0)) lead = 1'b0;
      supp[k] = lead && (k != 0);
    end
  end

  // Outputs come from the pre-edge index and shadows so a digit never mixes frames.
  always_comb begin
    nib     = 4'h0;
    dark    = 1'b0;
    pt      = 1'b0;
    sel_raw = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib        = data_sh_q[4*k +: 4];
        dark       = blank_sh_q[k] | supp[k];
        pt         = dp_sh_q[k];
        sel_raw[k] = 1'b1;
      end
    end
    seg_raw = dark ? 7'b0000000 : glyph(nib);
    seg_d   = seg_raw ^ {7{SEG_INV}};
    dp_d    = (pt & ~dark) ^ SEG_INV;
    sel_d   = sel_raw ^ {DIGITS{SEL_INV}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      data_sh_q  <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      tick_q     <= 1'b0;
      seg_q      <= {7{SEG_INV}};
      dp_q       <= SEG_INV;
      sel_q      <= {DIGITS{SEL_INV}};
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_sh_q  <= data_sh_d;
      dp_sh_q    <= dp_sh_d;
      blank_sh_q <= blank_sh_d;
      tick_q     <= tick_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
    end
  end

  assign segments  = seg_q;
  assign dp        = dp_q;
  assign digit_sel = sel_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_sevenseg_mux_display.sv
// Bench for sevenseg_mux_display: three configurations driven in parallel from
// shared stimulus, checked against a reference model through an expected queue.
module tb_sevenseg_mux_display;

  localparam int D  = 4;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   data;
  logic [3:0]    dp_in;
  logic [3:0]    blank;
  logic          load;

  logic [6:0]    seg_a, seg_b, seg_c;
  logic          dp_a, dp_b, dp_c;
  logic [3:0]    sel_a, sel_b, sel_c;
  logic          tick_a, tick_b, tick_c;

  always #5 clk = ~clk;

  // Hex glyphs, plain polarity.
  sevenseg_mux_display #(.DIGITS(D), .CLK_DIV(CD), .HEX_MODE(1), .LZ_SUPPRESS(0),
                         .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank), .load(load),
    .segments(seg_a), .dp(dp_a), .digit_sel(sel_a), .tick(tick_a));

  // Decimal glyphs with leading-zero suppression.
  sevenseg_mux_display #(.DIGITS(D), .CLK_DIV(CD), .HEX_MODE(0), .LZ_SUPPRESS(1),
                         .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_b (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank), .load(load),
    .segments(seg_b), .dp(dp_b), .digit_sel(sel_b), .tick(tick_b));

  // Hex glyphs, segments and selects active-low.
  sevenseg_mux_display #(.DIGITS(D), .CLK_DIV(CD), .HEX_MODE(1), .LZ_SUPPRESS(0),
                         .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_c (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank), .load(load),
    .segments(seg_c), .dp(dp_c), .digit_sel(sel_c), .tick(tick_c));

  int checks   = 0;
  int failures = 0;

  logic [38:0] exp_q[$];

  int          m_cnt;
  int          m_idx;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n, input bit hex);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1110011;
      4'hA: return hex ? 7'b1110111 : 7'b0000000;
      4'hB: return hex ? 7'b0011111 : 7'b0000000;
      4'hC: return hex ? 7'b1001110 : 7'b0000000;
      4'hD: return hex ? 7'b0111101 : 7'b0000000;
      4'hE: return hex ? 7'b1001111 : 7'b0000000;
      default: return hex ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction

  // Expected {tick, dp, digit_sel, segments} for the coming edge.
  function automatic logic [12:0] expect_out(input bit hex, input bit lz,
                                             input bit seg_low, input bit sel_low);
    logic       s;
    logic [3:0] nib;
    logic       dark;
    logic [6:0] seg;
    logic       pt;
    logic [3:0] sel;
    logic       tk;
    if (rst) return {1'b0, seg_low, {4{sel_low}}, {7{seg_low}}};
    s = lz && (m_idx > 0);
    for (int j = m_idx; j < D; j++) begin
      nib = m_data[4*j +: 4];
      if (nib != 4'h0 || m_dp[j]) s = 1'b0;
    end
    nib  = m_data[4*m_idx +: 4];
    dark = m_blank[m_idx] || s;
    seg  = dark ? 7'b0000000 : ref_glyph(nib, hex);
    pt   = dark ? 1'b0 : m_dp[m_idx];
    sel  = 4'b0001 << m_idx;
    tk   = (m_cnt == CD - 1);
    return {tk, pt ^ seg_low, sel ^ {4{sel_low}}, seg ^ {7{seg_low}}};
  endfunction

  task automatic check_inst(input string name, input logic [12:0] e, input logic t,
                            input logic p, input logic [3:0] s, input logic [6:0] g);
    check_eq({name, "_tick"}, 32'(t), 32'(e[12]));
    check_eq({name, "_dp"},   32'(p), 32'(e[11]));
    check_eq({name, "_sel"},  32'(s), 32'(e[10:7]));
    check_eq({name, "_seg"},  32'(g), 32'(e[6:0]));
  endtask

  task automatic cycle();
    logic [38:0] e;
    exp_q.push_back({expect_out(1, 0, 0, 0), expect_out(0, 1, 0, 0), expect_out(1, 0, 1, 1)});
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_data = '0; m_dp = '0; m_blank = '0;
    end else begin
      if (load) begin
        m_data = data; m_dp = dp_in; m_blank = blank;
      end
      if (m_cnt == CD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % D;
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_inst("hex", e[38:26], tick_a, dp_a, sel_a, seg_a);
      check_inst("dlz", e[25:13], tick_b, dp_b, sel_b, seg_b);
      check_inst("inv", e[12:0],  tick_c, dp_c, sel_c, seg_c);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_value(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data = d; dp_in = p; blank = b; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    m_cnt = 0; m_idx = 0; m_data = '0; m_dp = '0; m_blank = '0;
    rst = 1'b1; data = '0; dp_in = '0; blank = '0; load = 1'b0;
    run(3);
    rst = 1'b0;

    load_value(16'h1234, 4'b0000, 4'b0000);
    run(20);
    load_value(16'hABCF, 4'b0000, 4'b0000);
    run(16);
    load_value(16'h0050, 4'b0000, 4'b0000);
    run(16);
    load_value(16'h0000, 4'b0000, 4'b0000);
    run(16);
    load_value(16'h0000, 4'b0100, 4'b0000);
    run(16);
    load_value(16'h8888, 4'b0000, 4'b0010);
    run(16);

    // Inputs change without load: display must hold.
    data = 16'h5A5A; dp_in = 4'b1111; blank = 4'b0000;
    run(8);

    // Load on the cycle the index advances.
    for (int i = 0; i < 2 * CD && m_cnt != CD - 1; i++) cycle();
    load_value(16'h9076, 4'b0001, 4'b0000);
    run(12);

    // Randomised loads.
    for (int i = 0; i < 60; i++) begin
      data  = 16'($urandom) & (($urandom_range(0, 1) == 0) ? 16'h00FF : 16'hFFFF);
      dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      blank = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      load  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    load = 1'b0;

    // Reset mid-scan at index 2, with a load attempt that reset must override.
    load_value(16'h4321, 4'b0000, 4'b0000);
    for (int i = 0; i < 4 * CD && m_idx != 2; i++) cycle();
    run(1);
    rst = 1'b1; data = 16'hFFFF; load = 1'b1;
    cycle();
    rst = 1'b0; load = 1'b0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
